// File: rtl/router_pkg.sv
// Shared router definitions: datapath widths, reserved address and the
// controller state names used by both the FSM and the packet datapath.
package router_pkg;

  localparam int DATA_W = 8;
  localparam int LEN_W  = 6;

  localparam logic [1:0] ADDR_INVALID = 2'b11;

  // Controller states, one-hot so each bit doubles as a decode line.
  typedef enum logic [5:0] {
    ST_DECODE_ADDRESS     = 6'b000001,
    ST_LOAD_FIRST_DATA    = 6'b000010,
    ST_LOAD_DATA          = 6'b000100,
    ST_LOAD_AFTER_FULL    = 6'b001000,
    ST_FIFO_FULL_STATE    = 6'b010000,
    ST_CHECK_PARITY_ERROR = 6'b100000
  } ctrl_state_e;

  typedef struct packed {
    logic detect_addr;
    logic lfd_state;
    logic ld_state;
    logic laf_state;
    logic full_state;
    logic rst_int_req;
  } ctrl_decode_t;

  function automatic ctrl_decode_t decode_state(input ctrl_state_e s);
    ctrl_decode_t d;
    d.detect_addr = s[0];
    d.lfd_state   = s[1];
    d.ld_state    = s[2];
    d.laf_state   = s[3];
    d.full_state  = s[4];
    d.rst_int_req = s[5];
    return d;
  endfunction

  function automatic logic [LEN_W-1:0] sat_inc(input logic [LEN_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/packet_register_if.sv
// Byte-stream, FIFO-status and controller-decode signals between the
// router controller side (master) and the packet register (slave).
interface packet_register_if;
  import router_pkg::*;

  logic              pkt_valid;
  logic [DATA_W-1:0] din;
  logic              fifo_full;
  logic              detect_addr;
  logic              lfd_state;
  logic              ld_state;
  logic              laf_state;
  logic              full_state;
  logic              rst_int_req;
  logic [DATA_W-1:0] dout;
  logic              parity_done;
  logic              low_pkt_valid;
  logic              err;
  logic              len_err;

  modport master (
    output pkt_valid, din, fifo_full,
    output detect_addr, lfd_state, ld_state, laf_state, full_state, rst_int_req,
    input  dout, parity_done, low_pkt_valid, err, len_err
  );

  modport slave (
    input  pkt_valid, din, fifo_full,
    input  detect_addr, lfd_state, ld_state, laf_state, full_state, rst_int_req,
    output dout, parity_done, low_pkt_valid, err, len_err
  );

endinterface

// File: rtl/parity_acc.sv
// Running-XOR accumulator. Priority: reset, clear, load, xor.
module parity_acc
  import router_pkg::*;
#(
  parameter int W = DATA_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load,
  input  logic         xor_en,
  input  logic [W-1:0] d,
  output logic [W-1:0] acc
);

  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (load) begin
      acc <= d;
    end else if (xor_en) begin
      acc <= acc ^ d;
    end
  end

endmodule

// File: rtl/packet_register.sv
// Router packet register: header/full-byte holding, FIFO write data,
// running vs received parity check and payload length check.
module packet_register
  import router_pkg::*;
(
  input logic               clk,
  input logic               rst,
  packet_register_if.slave  bus
);

  ctrl_decode_t st;

  logic [DATA_W-1:0] hdr_reg;
  logic [DATA_W-1:0] full_byte;
  logic [DATA_W-1:0] pkt_parity;
  logic [DATA_W-1:0] dout_q;
  logic [DATA_W-1:0] run_parity;
  logic [LEN_W-1:0]  pay_cnt;
  logic              parity_done_q;
  logic              parity_done_prev;
  logic              low_pkt_valid_q;
  logic              err_q;
  logic              len_err_q;

  logic              accept;
  logic              par_from_din;
  logic              par_from_full;
  logic              pd_rise;
  logic              hdr_load;

  assign st = '{
    detect_addr: bus.detect_addr,
    lfd_state:   bus.lfd_state,
    ld_state:    bus.ld_state,
    laf_state:   bus.laf_state,
    full_state:  bus.full_state,
    rst_int_req: bus.rst_int_req
  };

  assign hdr_load      = st.detect_addr && bus.pkt_valid && (bus.din[1:0] != ADDR_INVALID);
  assign accept        = st.ld_state && bus.pkt_valid && !st.full_state;
  assign par_from_din  = st.ld_state && !bus.pkt_valid && !bus.fifo_full;
  assign par_from_full = st.laf_state && low_pkt_valid_q && !parity_done_q;
  assign pd_rise       = parity_done_q && !parity_done_prev;

  // The header enters the parity in LOAD_FIRST_DATA, payload bytes after.
  parity_acc #(.W(DATA_W)) u_parity_acc (
    .clk    (clk),
    .rst    (rst),
    .clr    (st.detect_addr),
    .load   (1'b0),
    .xor_en (st.lfd_state || accept),
    .d      (st.lfd_state ? hdr_reg : bus.din),
    .acc    (run_parity)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      hdr_reg   <= '0;
      full_byte <= '0;
      dout_q    <= '0;
    end else begin
      if (hdr_load) begin
        hdr_reg <= bus.din;
      end
      if (st.ld_state && bus.fifo_full) begin
        full_byte <= bus.din;
      end
      if (st.lfd_state) begin
        dout_q <= hdr_reg;
      end else if (st.ld_state) begin
        if (!bus.fifo_full) begin
          dout_q <= bus.din;
        end
      end else if (st.laf_state) begin
        dout_q <= full_byte;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pay_cnt <= '0;
    end else if (st.lfd_state) begin
      pay_cnt <= '0;
    end else if (accept) begin
      pay_cnt <= sat_inc(pay_cnt);
    end
  end

  // A parity byte that arrives while the FIFO is full is parked in
  // full_byte and captured later in LOAD_AFTER_FULL.
  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_parity       <= '0;
      parity_done_q    <= 1'b0;
      parity_done_prev <= 1'b0;
    end else begin
      parity_done_prev <= parity_done_q;
      if (par_from_din) begin
        pkt_parity <= bus.din;
      end else if (par_from_full) begin
        pkt_parity <= full_byte;
      end
      if (st.detect_addr) begin
        parity_done_q <= 1'b0;
      end else if (par_from_din || par_from_full) begin
        parity_done_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      low_pkt_valid_q <= 1'b0;
    end else if (st.rst_int_req) begin
      low_pkt_valid_q <= 1'b0;
    end else if (st.ld_state && !bus.pkt_valid) begin
      low_pkt_valid_q <= 1'b1;
    end
  end

  // Both checks are taken one cycle after the parity byte is captured.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q     <= 1'b0;
      len_err_q <= 1'b0;
    end else if (st.detect_addr) begin
      err_q     <= 1'b0;
      len_err_q <= 1'b0;
    end else if (pd_rise) begin
      err_q     <= (run_parity != pkt_parity);
      len_err_q <= (pay_cnt != hdr_reg[DATA_W-1:2]);
    end
  end

  assign bus.dout          = dout_q;
  assign bus.parity_done   = parity_done_q;
  assign bus.low_pkt_valid = low_pkt_valid_q;
  assign bus.err           = err_q;
  assign bus.len_err       = len_err_q;

endmodule

// File: doc/packet_register.md
PACKET_REGISTER -- requirements
Module: packet_register

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 The block SHALL have these ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- pkt_valid  in  1  source byte valid; deasserts on the parity byte
- din  in  8  source byte; header byte: [1:0] dest, [7:2] payload length
- fifo_full  in  1  selected FIFO full
- detect_addr  in  1  controller in DECODE_ADDRESS
- lfd_state  in  1  controller in LOAD_FIRST_DATA
- ld_state  in  1  controller in LOAD_DATA
- laf_state  in  1  controller in LOAD_AFTER_FULL
- full_state  in  1  controller in FIFO_FULL_STATE
- rst_int_req  in  1  controller in CHECK_PARITY_ERROR
- dout  out  8  byte to FIFO write port
- parity_done  out  1  parity byte captured
- low_pkt_valid  out  1  pkt_valid fell during LOAD_DATA
- err  out  1  parity mismatch
- len_err  out  1  payload count differs from header length

Function
REQ-003 Header capture: when detect_addr=1, pkt_valid=1 and din[1:0]!=2'b11, hdr_reg SHALL load din; dest 2'b11 SHALL NOT load.
REQ-004 dout SHALL be updated by the first matching rule, otherwise it holds:
- lfd_state: hdr_reg
- ld_state && !fifo_full: din
- ld_state && fifo_full: hold; din is stored into full_byte
- laf_state: full_byte
REQ-005 The running parity SHALL clear on detect_addr.
REQ-006 In lfd_state, the running parity SHALL XOR in hdr_reg.
REQ-007 In ld_state && pkt_valid && !full_state, the running parity SHALL XOR in din.
REQ-008 pkt_parity SHALL load din when ld_state && !pkt_valid && !fifo_full.
REQ-009 pkt_parity SHALL load full_byte when laf_state && low_pkt_valid && !parity_done.
REQ-010 parity_done SHALL set on the same conditions as REQ-008/REQ-009, and clear on detect_addr.
REQ-011 parity_done SHALL NOT be cleared by rst_int_req.
REQ-012 low_pkt_valid SHALL set when ld_state && !pkt_valid, and clear on rst_int_req.
REQ-013 If low_pkt_valid would set and clear in the same cycle, the clear SHALL win.
REQ-014 err SHALL register (running parity != pkt_parity) one cycle after parity_done rises, and clear on detect_addr.
REQ-015 Payload counter: 6-bit; clears in lfd_state; increments on each din accepted by REQ-007; saturates at 63.
REQ-016 len_err SHALL register (count != hdr_reg[7:2]) in the same cycle as err.
REQ-017 len_err SHALL clear on detect_addr.
REQ-018 A zero-length packet (hdr[7:2]=0) with an immediate parity byte SHALL give parity = header, err=0 and len_err=0.
REQ-019 full_byte SHALL be retained across any number of full_state cycles.

Reset
REQ-020 When rst=1 at a clock edge, dout, hdr_reg, full_byte, pkt_parity, running parity and counter SHALL go to 8'h00 / 0.
REQ-021 When rst=1 at a clock edge, parity_done, low_pkt_valid, err and len_err SHALL go to 0.
REQ-022 Reset SHALL override every other update, including mid-packet; no partial state SHALL survive.

Structure
REQ-023 The shared package router_pkg SHALL hold:
- DATA_W=8
- LEN_W=6
- ADDR_INVALID=2'b11
REQ-024 The controller state one-hot decode names SHALL be shared with the FSM controller.
REQ-025 One sub-module, parity_acc, SHALL hold the running-XOR accumulator with clear, load and xor-enable controls.
REQ-026 All other logic SHALL be inline.

Verification
REQ-027 Good packet: header 8'h0D (dest 1, len 3), payload 8'h11, 8'h22, 8'h33, parity 8'h0D^11^22^33=8'h0D -> dout sequence 0D,11,22,33,0D; parity_done=1; err=0; len_err=0.
REQ-028 Bad parity: same packet with parity 8'hFF -> err=1 one cycle after parity_done; detect_addr clears err.
REQ-029 FIFO full mid-payload: fifo_full=1 while ld_state with din=8'h22, then full_state for 3 cycles, then laf_state -> dout=8'h22 in laf_state; final parity correct, err=0.
REQ-030 Parity byte during full: pkt_valid=0 with fifo_full=1 -> low_pkt_valid=1; in laf_state -> parity_done=1 and pkt_parity=full_byte; rst_int_req clears low_pkt_valid.
REQ-031 Length mismatch: header len 4, only 2 payload bytes, correct parity -> err=0, len_err=1.
REQ-032 Reset mid-payload: rst=1 after 2 payload bytes -> all outputs 0 next cycle; a following good packet passes as in REQ-027.
